// File: rtl/spi_regfile_pkg.sv
// rtl/spi_regfile_pkg.sv - shared constants and frame sizing for the SPI register file
package spi_regfile_pkg;

    localparam logic OP_WRITE   = 1'b1;
    localparam logic OP_READ    = 1'b0;
    localparam int   DEF_ADDR_W = 7;
    localparam int   DEF_DATA_W = 8;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchronizer with optional rise/fall pulse detect
module spi_sync_edge #(
    parameter logic IDLE    = 1'b0,
    parameter bit   EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q, dly_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= IDLE;
            sync_q <= IDLE;
            dly_q  <= IDLE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = EDGE_EN & sync_q & ~dly_q;
    assign fall     = EDGE_EN & ~sync_q & dly_q;

endmodule

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI mode-0 slave giving read/write access to a parameterised register file
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int                          NUM_REGS  = 5,
    parameter int                          ADDR_W    = DEF_ADDR_W,
    parameter int                          DATA_W    = DEF_DATA_W,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         SCLK,
    input  logic                         nCS,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         addr_err
);

    localparam int               FRAME_W  = frame_w(ADDR_W, DATA_W);
    localparam int               CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic copi_s, copi_rise, copi_fall;

    spi_sync_edge #(.IDLE(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(reset), .async_in(SCLK),
        .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.IDLE(1'b1), .EDGE_EN(1'b0)) u_sync_ncs (
        .clk(clk), .rst_n(reset), .async_in(nCS),
        .sync_out(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.IDLE(1'b0), .EDGE_EN(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(reset), .async_in(COPI),
        .sync_out(copi_s), .rise(copi_rise), .fall(copi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, ncs_rise, ncs_fall, copi_rise, copi_fall};

    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               wr_pend_q, wr_pend_d;
    logic               rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic               tx_act_q, tx_act_d;
    logic               cipo_q, cipo_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               addr_err_q, addr_err_d;

    // Field views: full frame for the write decision, first 1+ADDR_W bits for reads.
    logic               wr_rw, rd_rw, wr_in_range, rd_in_range, commit;
    logic [ADDR_W-1:0]  wr_addr_f, rd_addr_f;
    logic [DATA_W-1:0]  wr_data, rd_data;

    assign wr_rw       = shift_q[FRAME_W-1];
    assign wr_addr_f   = shift_q[DATA_W +: ADDR_W];
    assign wr_data     = shift_q[DATA_W-1:0];
    assign rd_rw       = shift_q[ADDR_W];
    assign rd_addr_f   = shift_q[ADDR_W-1:0];
    assign wr_in_range = ({1'b0, wr_addr_f} < (ADDR_W+1)'(NUM_REGS));
    assign rd_in_range = ({1'b0, rd_addr_f} < (ADDR_W+1)'(NUM_REGS));

    // A deasserted nCS in the commit cycle cancels the write.
    assign commit = wr_pend_q & ~ncs_s & (wr_rw == OP_WRITE) & wr_in_range;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_f == ADDR_W'(i)) rd_data = regs_out[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wr_pend_d  = 1'b0;
        rd_pend_d  = 1'b0;
        tx_d       = tx_q;
        tx_act_d   = tx_act_q;
        cipo_d     = cipo_q;
        wr_addr_d  = wr_addr_q;
        addr_err_d = addr_err_q;
        if (ncs_s) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            tx_d      = '0;
            tx_act_d  = 1'b0;
            cipo_d    = 1'b0;
        end else begin
            if (sclk_rise && (bit_cnt_q != CNT_FULL)) begin
                shift_d   = {shift_q[FRAME_W-2:0], copi_s};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                wr_pend_d = (bit_cnt_q == CNT_LAST);
                rd_pend_d = (bit_cnt_q == CNT_ADDR);
            end
            if (rd_pend_q && (rd_rw == OP_READ)) begin
                tx_d     = rd_in_range ? rd_data : '0;
                tx_act_d = 1'b1;
                if (!rd_in_range) addr_err_d = 1'b1;
            end else if (sclk_fall && tx_act_q) begin
                cipo_d = tx_q[DATA_W-1];
                tx_d   = tx_q << 1;
            end
            if (wr_pend_q && (wr_rw == OP_WRITE) && !wr_in_range) addr_err_d = 1'b1;
        end
        if (commit) wr_addr_d = wr_addr_f;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            tx_q       <= '0;
            tx_act_q   <= 1'b0;
            cipo_q     <= 1'b0;
            wr_addr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            tx_q       <= tx_d;
            tx_act_q   <= tx_act_d;
            cipo_q     <= cipo_d;
            wr_addr_q  <= wr_addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_W-1:0] reg_q, reg_d;

        always_comb begin
            reg_d = reg_q;
            if (commit && (wr_addr_f == ADDR_W'(g))) reg_d = wr_data;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) reg_q <= RESET_VAL[g*DATA_W +: DATA_W];
            else        reg_q <= reg_d;
        end

        assign regs_out[g*DATA_W +: DATA_W] = reg_q;
    end

    assign CIPO      = cipo_q;
    assign CIPO_oe   = ~ncs_s;
    assign wr_strobe = commit;
    assign wr_addr   = wr_addr_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_regfile.sv
// tb/tb_spi_regfile.sv - scoreboard bench for spi_regfile (default and 16x16 configurations)
module tb_spi_regfile;

    localparam logic [255:0] RV1 = {16{16'h5A5A}};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic SCLK  = 1'b0;
    logic COPI  = 1'b0;
    logic ncs0  = 1'b1;
    logic ncs1  = 1'b1;

    logic        cipo0, oe0, stb0, aerr0;
    logic [39:0] regs0;
    logic [6:0]  waddr0;
    logic        cipo1, oe1, stb1, aerr1;
    logic [255:0] regs1;
    logic [6:0]  waddr1;

    spi_regfile dut0 (
        .clk(clk), .reset(reset), .SCLK(SCLK), .nCS(ncs0), .COPI(COPI),
        .CIPO(cipo0), .CIPO_oe(oe0), .regs_out(regs0),
        .wr_strobe(stb0), .wr_addr(waddr0), .addr_err(aerr0)
    );

    spi_regfile #(.NUM_REGS(16), .ADDR_W(7), .DATA_W(16), .RESET_VAL(RV1)) dut1 (
        .clk(clk), .reset(reset), .SCLK(SCLK), .nCS(ncs1), .COPI(COPI),
        .CIPO(cipo1), .CIPO_oe(oe1), .regs_out(regs1),
        .wr_strobe(stb1), .wr_addr(waddr1), .addr_err(aerr1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  a;
        logic [15:0] d;
    } wexp_t;

    wexp_t       wq0[$];
    wexp_t       wq1[$];
    logic [7:0]  rq[$];
    logic [39:0] img0;
    logic [255:0] img1;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Frame driver: SCLK phases are 4 clk each, edges aligned to clk falling edges.
    task automatic spi_xfer(input int dut, input logic [31:0] frame, input int flen,
                            input int nclk, input bit lat, input int rst_at);
        if (dut == 0) ncs0 = 1'b0; else ncs1 = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < nclk; k++) begin
            COPI = (k < flen) ? frame[flen-1-k] : 1'b0;
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            for (int h = 1; h <= 4; h++) begin
                @(negedge clk);
                if (k == 0 && h == 4) chk("cipo_oe_in_frame", (dut == 0) ? oe0 : oe1, 1);
                if (lat && k == flen - 1 && h == 3) chk("strobe_commit_cycle", (dut == 0) ? stb0 : stb1, 1);
                if (lat && k == flen - 1 && h == 4) chk("strobe_single_cycle", (dut == 0) ? stb0 : stb1, 0);
            end
            SCLK = 1'b0;
            if (k + 1 == rst_at) begin
                #2 reset = 1'b0;
                #1;
                chk("async_reset_regs0", regs0, 0);
                chk("async_reset_regs1", regs1, RV1);
                chk("async_reset_aerr0", aerr0, 0);
                chk("async_reset_oe0", oe0, 0);
                @(negedge clk);
                reset = 1'b1;
                img0 = '0;
                img1 = RV1;
            end
        end
        COPI = 1'b0;
        repeat (4) @(negedge clk);
        if (dut == 0) ncs0 = 1'b1; else ncs1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("cipo_oe_idle", (dut == 0) ? oe0 : oe1, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset && stb0) begin
                if (wq0.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL wr0_unexpected got=strobe addr_field exp=no_strobe");
                end else begin
                    wexp_t e;
                    e = wq0.pop_front();
                    @(posedge clk);
                    #1;
                    chk("wr0_addr", waddr0, e.a);
                    chk("wr0_data", regs0[int'(e.a)*8 +: 8], e.d[7:0]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset && stb1) begin
                if (wq1.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL wr1_unexpected got=strobe exp=no_strobe");
                end else begin
                    wexp_t e;
                    e = wq1.pop_front();
                    @(posedge clk);
                    #1;
                    chk("wr1_addr", waddr1, e.a);
                    chk("wr1_data", regs1[int'(e.a)*16 +: 16], e.d);
                end
            end
        end
    end

    int         rb;
    logic       rop;
    logic [7:0] rcap;

    initial begin
        forever begin
            @(negedge ncs0);
            rb   = 0;
            rop  = 1'b1;
            rcap = '0;
            while (ncs0 == 1'b0) begin
                @(posedge SCLK or posedge ncs0);
                if (!ncs0) begin
                    if (rb == 0) rop = COPI;
                    if (rb >= 8 && rb < 16) rcap = {rcap[6:0], cipo0};
                    rb++;
                end
            end
            if (rop == 1'b0 && rb >= 16) begin
                if (rq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rd_unexpected got=%0h exp=no_read", rcap);
                end else begin
                    chk("rd_data", rcap, rq.pop_front());
                end
            end
        end
    end

    initial begin
        img0 = '0;
        img1 = RV1;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_regs0", regs0, 0);
        chk("rst_regs1", regs1, RV1);
        chk("rst_cipo0", cipo0, 0);
        chk("rst_oe0", oe0, 0);
        chk("rst_stb0", stb0, 0);
        chk("rst_waddr0", waddr0, 0);
        chk("rst_aerr0", aerr0, 0);
        chk("rst_aerr1", aerr1, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        wq0.push_back('{7'd2, 16'h00A5});
        spi_xfer(0, 32'h82A5, 16, 16, 1, -1);
        img0[16 +: 8] = 8'hA5;
        chk("img0_w2", regs0, img0);
        chk("waddr0_w2", waddr0, 2);

        wq0.push_back('{7'd2, 16'h00A5});
        spi_xfer(0, 32'h82A5, 16, 20, 1, -1);
        chk("img0_w2_20clk", regs0, img0);

        rq.push_back(8'hA5);
        spi_xfer(0, 32'h0200, 16, 16, 0, -1);
        chk("img0_after_read", regs0, img0);

        spi_xfer(0, 32'h84FF, 16, 10, 0, -1);
        chk("img0_aborted", regs0, img0);

        wq0.push_back('{7'd4, 16'h0033});
        spi_xfer(0, 32'h8433, 16, 16, 1, -1);
        img0[32 +: 8] = 8'h33;
        chk("img0_w4", regs0, img0);

        rq.push_back(8'h33);
        spi_xfer(0, 32'h0400, 16, 16, 0, -1);
        chk("aerr0_clean", aerr0, 0);

        spi_xfer(0, 32'h8711, 16, 16, 0, -1);
        chk("img0_oor_write", regs0, img0);
        chk("aerr0_set", aerr0, 1);

        wq0.push_back('{7'd0, 16'h005A});
        spi_xfer(0, 32'h805A, 16, 16, 1, -1);
        img0[0 +: 8] = 8'h5A;
        chk("img0_w0", regs0, img0);
        chk("aerr0_sticky", aerr0, 1);

        rq.push_back(8'h00);
        spi_xfer(0, 32'h0600, 16, 16, 0, -1);
        chk("img0_oor_read", regs0, img0);

        spi_xfer(0, 32'h8199, 16, 16, 0, 12);
        chk("img0_after_reset_frame", regs0, img0);
        chk("waddr0_after_reset", waddr0, 0);
        chk("aerr0_after_reset", aerr0, 0);

        wq1.push_back('{7'd15, 16'hBEEF});
        spi_xfer(1, 32'h008FBEEF, 24, 24, 1, -1);
        img1[15*16 +: 16] = 16'hBEEF;
        chk("img1_w15", regs1, img1);
        chk("waddr1_w15", waddr1, 15);
        chk("img0_untouched", regs0, img0);
        chk("cipo1_idle", cipo1, 0);

        repeat (10) @(negedge clk);
        chk("wq0_drained", wq0.size(), 0);
        chk("wq1_drained", wq1.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
